// File: rtl/etapa_exe_pipe.sv
// etapa_exe_pipe: two-stage pipelined SIMD execute stage.
// S1 registers the selected operands. S2 either computes a single-cycle
// result or runs an iterative per-lane shift-add multiply. Results leave
// over a valid/ready handshake.
module etapa_exe_pipe #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int DIR_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   vector_a,
  input  logic [LANES*LANE_W-1:0]   vfs,
  input  logic [LANES*LANE_W-1:0]   vector_ad,
  input  logic [LANES*LANE_W-1:0]   vector_b,
  input  logic [LANE_W-1:0]         out_s,
  input  logic [LANE_W-1:0]         shamt,
  input  logic [LANE_W-1:0]         inmediate_in,
  input  logic [DIR_W-1:0]          dir_dest_in,
  input  logic [3:0]                opcode,
  input  logic [1:0]                sel_vec,
  input  logic                      sel_int,
  input  logic                      sel_op,
  input  logic                      sat_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   data1_out,
  output logic [LANES*LANE_W-1:0]   alu_result,
  output logic [LANE_W-1:0]         inmediate_out,
  output logic [DIR_W-1:0]          dir_dest_out,
  output logic                      busy
);

  localparam int VW    = LANES * LANE_W;
  localparam int SHW   = $clog2(LANE_W);
  localparam int CNT_W = $clog2(LANE_W) + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_MIN = 4'd9;
  localparam logic [3:0] OP_MAX = 4'd10;

  typedef enum logic [1:0] {ST_EMPTY, ST_MUL_RUN, ST_FULL} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;

  logic               s1_valid_reg;
  logic [VW-1:0]      s1_a_reg, s1_b_reg;
  logic [3:0]         s1_op_reg;
  logic               s1_sat_reg;
  logic [LANE_W-1:0]  s1_imm_reg;
  logic [DIR_W-1:0]   s1_dir_reg;

  logic [VW-1:0]      res_reg, data1_reg;
  logic [LANE_W-1:0]  imm_reg;
  logic [DIR_W-1:0]   dir_reg;

  logic [LANE_W-1:0]  scalar_sel;
  logic [VW-1:0]      a_sel, b_sel;
  logic [VW-1:0]      alu_vec, mul_vec;
  logic               s1_adv, s1_load, s1_is_mul, mul_last;

  // S1 hands its bundle to S2 when S2 is empty or its result retires now
  assign s1_adv    = s1_valid_reg && ((state_reg == ST_EMPTY) ||
                                      ((state_reg == ST_FULL) && out_ready));
  assign in_ready  = rst_n && (!s1_valid_reg || s1_adv);
  assign s1_load   = in_valid && in_ready;
  assign s1_is_mul = (s1_op_reg == OP_MUL);
  assign mul_last  = (state_reg == ST_MUL_RUN) && (cnt_reg == CNT_W'(1));

  // Operand A source mux and operand B vector / broadcast-scalar mux
  always_comb begin
    scalar_sel = sel_op ? shamt : out_s;
    case (sel_vec)
      2'd0:    a_sel = vector_a;
      2'd1:    a_sel = vfs;
      2'd2:    a_sel = vector_ad;
      default: a_sel = '0;
    endcase
    b_sel = sel_int ? {LANES{scalar_sel}} : vector_b;
  end

  // S1 operand register; valid drops when drained without a refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_op_reg    <= '0;
      s1_sat_reg   <= 1'b0;
      s1_imm_reg   <= '0;
      s1_dir_reg   <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= 1'b1;
      s1_a_reg     <= a_sel;
      s1_b_reg     <= b_sel;
      s1_op_reg    <= opcode;
      s1_sat_reg   <= sat_en;
      s1_imm_reg   <= inmediate_in;
      s1_dir_reg   <= dir_dest_in;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] a, b, sum, diff, sat_val, res;
      logic [SHW-1:0]    sh;
      logic              ovf_add, ovf_sub;
      logic [LANE_W-1:0] acc_reg, mcand_reg, mplier_reg, acc_step;

      assign a       = s1_a_reg[gi*LANE_W +: LANE_W];
      assign b       = s1_b_reg[gi*LANE_W +: LANE_W];
      assign sh      = b[SHW-1:0];
      assign sum     = a + b;
      assign diff    = a - b;
      assign ovf_add = (a[LANE_W-1] == b[LANE_W-1]) && (sum[LANE_W-1]  != a[LANE_W-1]);
      assign ovf_sub = (a[LANE_W-1] != b[LANE_W-1]) && (diff[LANE_W-1] != a[LANE_W-1]);
      // Overflow always takes the sign of A, so the clamp follows A's sign
      assign sat_val = a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};

      // Single-cycle lane ALU; MUL and unused opcodes fall through to pass-A
      always_comb begin
        res = a;
        case (s1_op_reg)
          OP_ADD: res = (s1_sat_reg && ovf_add) ? sat_val : sum;
          OP_SUB: res = (s1_sat_reg && ovf_sub) ? sat_val : diff;
          OP_AND: res = a & b;
          OP_OR:  res = a | b;
          OP_XOR: res = a ^ b;
          OP_SLL: res = a << sh;
          OP_SRL: res = a >> sh;
          OP_SRA: res = $signed(a) >>> sh;
          OP_MIN: res = ($signed(a) < $signed(b)) ? a : b;
          OP_MAX: res = ($signed(a) > $signed(b)) ? a : b;
          default: res = a;
        endcase
      end

      assign alu_vec[gi*LANE_W +: LANE_W] = res;

      // Only the low LANE_W product bits matter, so every register is lane-wide
      assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
      assign mul_vec[gi*LANE_W +: LANE_W] = acc_step;

      // Shift-add multiply state: seeded on issue, one partial product per cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg    <= '0;
          mcand_reg  <= '0;
          mplier_reg <= '0;
        end else if (s1_adv && s1_is_mul) begin
          acc_reg    <= '0;
          mcand_reg  <= a;
          mplier_reg <= b;
        end else if (state_reg == ST_MUL_RUN) begin
          acc_reg    <= acc_step;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
        end
      end
    end
  endgenerate

  // S2 state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_EMPTY;
    else        state_reg <= state_next;
  end

  // S2 next-state: issue from S1, finish multiply, retire on out_ready
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (s1_adv) state_next = s1_is_mul ? ST_MUL_RUN : ST_FULL;
      end
      ST_MUL_RUN: begin
        if (mul_last) state_next = ST_FULL;
      end
      ST_FULL: begin
        if (out_ready) begin
          if (s1_adv) state_next = s1_is_mul ? ST_MUL_RUN : ST_FULL;
          else        state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // S2 status outputs decoded from state
  always_comb begin
    out_valid = (state_reg == ST_FULL);
    busy      = (state_reg == ST_MUL_RUN);
  end

  // Multiply iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt_reg <= '0;
    else if (s1_adv && s1_is_mul) cnt_reg <= CNT_W'(LANE_W);
    else if (state_reg == ST_MUL_RUN) cnt_reg <= cnt_reg - CNT_W'(1);
  end

  // S2 result and sideband registers; held whenever nothing issues or completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_reg   <= '0;
      data1_reg <= '0;
      imm_reg   <= '0;
      dir_reg   <= '0;
    end else if (s1_adv) begin
      data1_reg <= s1_a_reg;
      imm_reg   <= s1_imm_reg;
      dir_reg   <= s1_dir_reg;
      if (!s1_is_mul) res_reg <= alu_vec;
    end else if (mul_last) begin
      res_reg <= mul_vec;
    end
  end

  assign alu_result    = res_reg;
  assign data1_out     = data1_reg;
  assign inmediate_out = imm_reg;
  assign dir_dest_out  = dir_reg;

endmodule

// File: tb/tb_etapa_exe_pipe.sv
// Directed testbench for etapa_exe_pipe (LANES=4, LANE_W=8, DIR_W=3).
module tb_etapa_exe_pipe;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int DIR_W  = 3;
  localparam int VW     = LANES * LANE_W;

  logic              clk, rst_n, in_valid, in_ready;
  logic [VW-1:0]     vector_a, vfs, vector_ad, vector_b;
  logic [LANE_W-1:0] out_s, shamt, inmediate_in;
  logic [DIR_W-1:0]  dir_dest_in;
  logic [3:0]        opcode;
  logic [1:0]        sel_vec;
  logic              sel_int, sel_op, sat_en;
  logic              out_valid, out_ready, busy;
  logic [VW-1:0]     data1_out, alu_result;
  logic [LANE_W-1:0] inmediate_out;
  logic [DIR_W-1:0]  dir_dest_out;

  int checks = 0;
  int errors = 0;

  etapa_exe_pipe #(.LANES(LANES), .LANE_W(LANE_W), .DIR_W(DIR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .vector_a(vector_a), .vfs(vfs), .vector_ad(vector_ad), .vector_b(vector_b),
    .out_s(out_s), .shamt(shamt), .inmediate_in(inmediate_in), .dir_dest_in(dir_dest_in),
    .opcode(opcode), .sel_vec(sel_vec), .sel_int(sel_int), .sel_op(sel_op), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .data1_out(data1_out),
    .alu_result(alu_result), .inmediate_out(inmediate_out), .dir_dest_out(dir_dest_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [1:0] sv, input logic si, input logic so,
                            input logic [31:0] va, input logic [31:0] vf,
                            input logic [31:0] vd, input logic [31:0] vb,
                            input logic [7:0] os, input logic [7:0] sh,
                            input logic [3:0] op, input logic sat);
    sel_vec = sv; sel_int = si; sel_op = so;
    vector_a = va; vfs = vf; vector_ad = vd; vector_b = vb;
    out_s = os; shamt = sh; opcode = op; sat_en = sat;
  endtask

  task automatic send(input logic [1:0] sv, input logic si, input logic so,
                      input logic [31:0] va, input logic [31:0] vf,
                      input logic [31:0] vd, input logic [31:0] vb,
                      input logic [7:0] os, input logic [7:0] sh,
                      input logic [3:0] op, input logic sat);
    set_bundle(sv, si, so, va, vf, vd, vb, os, sh, op, sat);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inmediate_in = '0; dir_dest_in = '0;
    set_bundle(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h0, 8'h0, 4'd0, 1'b0);
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL reset_alu_result got %h want 0", alu_result); end
    checks++; if (data1_out !== 32'h0) begin errors++; $display("FAIL reset_data1_out got %h want 0", data1_out); end
    checks++; if (inmediate_out !== 8'h0 || dir_dest_out !== 3'd0) begin errors++; $display("FAIL reset_sideband got %h/%h want 0/0", inmediate_out, dir_dest_out); end
    @(posedge clk); #1; rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add_sub;
    out_ready = 1'b1; inmediate_in = 8'h5A; dir_dest_in = 3'd5;
    send(2'd0, 1'b0, 1'b0, 32'h7F01FF10, 32'h0, 32'h0, 32'h01010110, 8'h0, 8'h0, 4'd0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_early got %b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b want 1", out_valid); end
    checks++; if (alu_result !== 32'h80020020) begin errors++; $display("FAIL add_wrap got %h want 80020020", alu_result); end
    checks++; if (inmediate_out !== 8'h5A || dir_dest_out !== 3'd5) begin errors++; $display("FAIL add_sideband got %h/%h want 5a/5", inmediate_out, dir_dest_out); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_retire got %b want 0", out_valid); end
    send(2'd0, 1'b0, 1'b0, 32'h7F01FF10, 32'h0, 32'h0, 32'h01010110, 8'h0, 8'h0, 4'd0, 1'b1);
    step();
    checks++; if (alu_result !== 32'h7F020020) begin errors++; $display("FAIL add_sat got %h want 7f020020", alu_result); end
    step();
    send(2'd0, 1'b0, 1'b0, 32'h10200380, 32'h0, 32'h0, 32'h01010101, 8'h0, 8'h0, 4'd1, 1'b1);
    step();
    checks++; if (alu_result !== 32'h0F1F0280) begin errors++; $display("FAIL sub_sat got %h want 0f1f0280", alu_result); end
    step();
    send(2'd0, 1'b0, 1'b0, 32'h10200380, 32'h0, 32'h0, 32'h01010101, 8'h0, 8'h0, 4'd1, 1'b0);
    step();
    checks++; if (alu_result !== 32'h0F1F027F) begin errors++; $display("FAIL sub_wrap got %h want 0f1f027f", alu_result); end
    step();
  endtask

  task automatic test_broadcast_shift;
    out_ready = 1'b1;
    send(2'd0, 1'b1, 1'b1, 32'h01020408, 32'h0, 32'h0, 32'hFFFFFFFF, 8'h55, 8'h03, 4'd5, 1'b0);
    step();
    checks++; if (alu_result !== 32'h08102040) begin errors++; $display("FAIL sll_bcast got %h want 08102040", alu_result); end
    checks++; if (data1_out !== 32'h01020408) begin errors++; $display("FAIL sll_data1 got %h want 01020408", data1_out); end
    step();
    send(2'd0, 1'b1, 1'b0, 32'h80F07F02, 32'h0, 32'h0, 32'hFFFFFFFF, 8'h01, 8'h07, 4'd7, 1'b0);
    step();
    checks++; if (alu_result !== 32'hC0F83F01) begin errors++; $display("FAIL sra_bcast got %h want c0f83f01", alu_result); end
    step();
    send(2'd1, 1'b1, 1'b0, 32'h11111111, 32'h80F0FF10, 32'h22222222, 32'h0, 8'h04, 8'h01, 4'd6, 1'b0);
    step();
    checks++; if (alu_result !== 32'h080F0F01) begin errors++; $display("FAIL srl_vfs got %h want 080f0f01", alu_result); end
    checks++; if (data1_out !== 32'h80F0FF10) begin errors++; $display("FAIL srl_vfs_data1 got %h want 80f0ff10", data1_out); end
    step();
  endtask

  task automatic test_ops;
    out_ready = 1'b1;
    send(2'd2, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 32'h807F0105, 32'h01800305, 8'h0, 8'h0, 4'd10, 1'b0);
    step();
    checks++; if (alu_result !== 32'h017F0305) begin errors++; $display("FAIL max_signed got %h want 017f0305", alu_result); end
    checks++; if (data1_out !== 32'h807F0105) begin errors++; $display("FAIL max_data1 got %h want 807f0105", data1_out); end
    step();
    send(2'd2, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 32'h807F0105, 32'h01800305, 8'h0, 8'h0, 4'd9, 1'b0);
    step();
    checks++; if (alu_result !== 32'h80800105) begin errors++; $display("FAIL min_signed got %h want 80800105", alu_result); end
    step();
    send(2'd3, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h12345678, 8'h0, 8'h0, 4'd3, 1'b0);
    step();
    checks++; if (alu_result !== 32'h12345678 || data1_out !== 32'h0) begin errors++; $display("FAIL or_zero_a got %h/%h want 12345678/0", alu_result, data1_out); end
    step();
    send(2'd0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h12345678, 8'h0, 8'h0, 4'd12, 1'b0);
    step();
    checks++; if (alu_result !== 32'hDEADBEEF) begin errors++; $display("FAIL pass_a got %h want deadbeef", alu_result); end
    step();
  endtask

  task automatic test_mul;
    out_ready = 1'b1;
    send(2'd0, 1'b0, 1'b0, 32'h0310FF07, 32'h0, 32'h0, 32'h05100209, 8'h0, 8'h0, 4'd8, 1'b0);
    set_bundle(2'd0, 1'b0, 1'b0, 32'h01020304, 32'h0, 32'h0, 32'h01010101, 8'h0, 8'h0, 4'd0, 1'b0);
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_second_offer got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < LANE_W; i++) begin
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL mul_run_%0d got busy=%b valid=%b ready=%b want 1/0/0", i, busy, out_valid, in_ready);
      end
      step();
    end
    checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mul_done got valid=%b busy=%b want 1/0", out_valid, busy); end
    checks++; if (alu_result !== 32'h0F00FE3F) begin errors++; $display("FAIL mul_result got %h want 0f00fe3f", alu_result); end
    step();
    checks++; if (out_valid !== 1'b1 || alu_result !== 32'h02030405) begin errors++; $display("FAIL mul_followon got %b/%h want 1/02030405", out_valid, alu_result); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q[$];
    logic [31:0] prev_res, prev_d1;
    logic        prev_stall, acc, pop;
    int          sent, got;
    sent = 0; got = 0; prev_stall = 1'b0; prev_res = '0; prev_d1 = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      if (out_valid) begin
        if (prev_stall) begin
          checks++; if (alu_result !== prev_res || data1_out !== prev_d1) begin
            errors++; $display("FAIL b2b_hold got %h/%h want %h/%h", alu_result, data1_out, prev_res, prev_d1);
          end
        end
        checks++; if (exp_q.size() == 0 || alu_result !== exp_q[0]) begin
          errors++; $display("FAIL b2b_order got %h want %h", alu_result, (exp_q.size() != 0) ? exp_q[0] : 32'hx);
        end
      end
      out_ready = (cyc % 3 == 0);
      if (sent < 8) begin
        set_bundle(2'd0, 1'b0, 1'b0, 32'h01010101 * (sent + 1), 32'h0, 32'h0, 32'h10203040, 8'h0, 8'h0, 4'd0, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_res = alu_result;
      prev_d1 = data1_out;
      if (acc) begin
        exp_q.push_back(32'h11213141 + 32'h01010101 * sent);
        sent++;
      end
      step();
      if (pop && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 8 || sent != 8) begin errors++; $display("FAIL b2b_count got %0d/%0d want 8/8", got, sent); end
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul;
    out_ready = 1'b1; inmediate_in = 8'hC3; dir_dest_in = 3'd6;
    send(2'd0, 1'b0, 1'b0, 32'h0310FF07, 32'h0, 32'h0, 32'h05100209, 8'h0, 8'h0, 4'd8, 1'b0);
    step(); step(); step(); step();
    checks++; if (busy !== 1'b1 || data1_out !== 32'h0310FF07) begin errors++; $display("FAIL rmul_pre got %b/%h want 1/0310ff07", busy, data1_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rmul_ctrl got %b/%b/%b want 0/0/0", out_valid, busy, in_ready); end
    checks++; if (alu_result !== 32'h0 || data1_out !== 32'h0) begin errors++; $display("FAIL rmul_data got %h/%h want 0/0", alu_result, data1_out); end
    checks++; if (inmediate_out !== 8'h0 || dir_dest_out !== 3'd0) begin errors++; $display("FAIL rmul_side got %h/%h want 0/0", inmediate_out, dir_dest_out); end
    @(posedge clk); #1; rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmul_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmul_spurious_%0d got %b/%b want 0/0", i, out_valid, busy); end
    end
    send(2'd0, 1'b0, 1'b0, 32'h01020304, 32'h0, 32'h0, 32'h01010101, 8'h0, 8'h0, 4'd0, 1'b0);
    step();
    checks++; if (out_valid !== 1'b1 || alu_result !== 32'h02030405) begin errors++; $display("FAIL rmul_after got %b/%h want 1/02030405", out_valid, alu_result); end
    step();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_broadcast_shift();
    test_ops();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/etapa_exe_pipe.md
# etapa_exe_pipe

Parametrised, pipelined execute stage for the vector processor. It takes LANES lanes of LANE_W-bit data and selects operand A from the vector sources and operand B from a vector or a broadcast scalar. It runs all lanes in parallel through a registered ALU and returns results over a valid/ready handshake. Single-cycle ops stream at one per clock; MUL is an iterative shift-add that stalls the stage for LANE_W cycles. Optional signed saturation applies to ADD/SUB.

## Interface
- LANES, 4, number of parallel lanes
- LANE_W, 8, bits per lane (power of two, ≥4)
- DIR_W, 3, destination-register address width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input bundle valid
- in_ready  out  1  stage can accept input
- vector_a, vfs, vector_ad, vector_b  in  LANES*LANE_W  vector operands, lane i at [i*LANE_W +: LANE_W]
- out_s, shamt, inmediate_in  in  LANE_W  scalar operands / immediate
- dir_dest_in  in  DIR_W  destination register
- opcode  in  4  ALU operation
- sel_vec  in  2  A source: 0 vector_a, 1 vfs, 2 vector_ad, 3 zero
- sel_int  in  1  B source: 0 vector_b, 1 broadcast scalar
- sel_op  in  1  scalar: 0 out_s, 1 shamt
- sat_en  in  1  signed saturation for ADD/SUB
- out_valid  out  1  result bundle valid
- out_ready  in  1  consumer accepts result
- data1_out, alu_result  out  LANES*LANE_W  selected operand A / lane results
- inmediate_out  out  LANE_W; dir_dest_out  out  DIR_W  sideband copies, aligned with alu_result
- busy  out  1  high while MUL iterates

## Operation
- Two pipeline stages. S1 holds the operand register plus s1_valid. S2 holds the result register and an FSM with states EMPTY, MUL_RUN, FULL.
- S1 stage:
  - S1 loads on in_valid && in_ready. It captures A, B (scalar replicated to every lane when sel_int=1), opcode, sat_en and sideband.
  - in_ready = rst_n && (!s1_valid || s1_adv).
  - s1_adv = s1_valid && (state==EMPTY || (state==FULL && out_ready)).
- On s1_adv the S2 target state depends on the op:
  - Non-MUL op: state→FULL with the result computed in that cycle.
  - MUL: state→MUL_RUN, with cnt=LANE_W, accumulator=0, multiplicand=A, multiplier=B.
- MUL_RUN, each cycle, per lane: if multiplier LSB is 1, acc+=multiplicand; multiplicand<<=1; multiplier>>=1; cnt−−. When cnt reaches 0 → FULL. busy=1 in MUL_RUN.
- FULL: out_valid=1, outputs stable. On out_ready, go to EMPTY, or load the next S1 entry in the same cycle.
- Opcodes (per lane, mod 2^LANE_W):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA: shift amount = B[log2(LANE_W)-1:0]
  - 8 MUL: low LANE_W bits of the product
  - 9 MIN, 10 MAX: signed
  - 11–15: pass A
- Saturation (sat_en=1, ADD/SUB only): on signed overflow, the lane clamps to 0x7F…/0x80… per sign. When sat_en=0 results wrap. Lanes never carry into each other.
- data1_out is the selected A, registered alongside the result.

## Timing
- Reset (rst_n low, async): s1_valid=0, state=EMPTY, cnt=0, out_valid=0, busy=0, in_ready=0. data1_out, alu_result, inmediate_out and dir_dest_out all =0.
- Non-MUL latency: accepted at edge k → out_valid high after edge k+1. Throughput is 1/clk while out_ready=1.
- MUL latency: accepted at edge k → MUL_RUN after k+1 → FULL after edge k+1+LANE_W.
- While MUL_RUN, S1 may hold one waiting bundle. in_ready stays low until S1 drains.
- Backpressure: with out_valid && !out_ready, all outputs are held unchanged. S1 fills once, then in_ready=0.
- Simultaneous out_ready with a valid S1 in FULL: the old result retires and the new one loads at the same edge, with no bubble.
- Reset mid-MUL: the op is discarded, and out_valid stays 0 after release until a new accept.
- Input bundle fields must be stable only in cycles where in_valid && in_ready.

## Test plan
- ADD wrap, LANES=4, LANE_W=8: A=0x7F01FF10, B=0x01010110, sat_en=0, out_ready=1 → alu_result=0x80020020, out_valid one cycle after the S1 load.
- ADD saturate, same operands with sat_en=1 → 0x7F020020. SUB with A lane=0x80, B lane=0x01, sat_en=1 → that lane 0x80.
- Broadcast shift: sel_vec=0, sel_int=1, sel_op=1, shamt=0x03, opcode SLL, A=0x01020408 → 0x08102040, data1_out=0x01020408.
- MUL: A=0x0310FF07, B=0x05100209 → 0x0F00FE3F, valid 9 edges after accept. A second bundle is offered immediately: it is accepted into S1, then in_ready=0 until MUL completes.
- Streaming and backpressure: 8 back-to-back ADDs with out_ready toggling 1,0,0,1… → no loss or duplication, in order, outputs stable while stalled.
- Reset asserted during cycle 4 of MUL_RUN → all outputs 0 immediately. After release, in_ready=1 and no spurious out_valid.
